reg_write_arbiter: RTL and testbench

// - Shares the single register-file write port (WRITE/INADDRESS/IN) between two writeback requesters:
//   ALU result (A) and memory load (M). Sits between the execute/memory stages and reg_file.
// - Each requester has a 1-entry holding buffer with valid/ready handshake; the arbiter grants one

---
 rtl/reg_write_arbiter.sv | 119 +++++++++++
 tb/tb_reg_write_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Two-requester writeback arbiter (ALU / load) driving the register-file write port.
// Optional REGWR_HAZARD_EN adds RD1_ADDR/RD2_ADDR inputs and the HAZARD output.
module reg_write_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 3,
    parameter int PRIO_MODE = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              A_VALID,
    output logic              A_READY,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_DATA,
    input  logic              M_VALID,
    output logic              M_READY,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_DATA,
`ifdef REGWR_HAZARD_EN
    input  logic [ADDR_W-1:0] RD1_ADDR,
    input  logic [ADDR_W-1:0] RD2_ADDR,
    output logic              HAZARD,
`endif
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN
);

    typedef enum logic {GRANT_A = 1'b0, GRANT_M = 1'b1} grant_t;

    grant_t            last_grant, last_grant_next;
    logic              a_full, m_full;
    logic [ADDR_W-1:0] a_addr, m_addr;
    logic [DATA_W-1:0] a_data, m_data;
    logic              grant_a, grant_m;
    logic              a_accept, m_accept;

    always_ff @(posedge CLK) begin
        if (RESET) last_grant <= GRANT_M;
        else       last_grant <= last_grant_next;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        grant_a         = 1'b0;
        grant_m         = 1'b0;
        last_grant_next = last_grant;
        if (a_full && m_full) begin
            if (PRIO_MODE == 1) begin
                grant_a = 1'b1;
            end else begin
                // Tie: the requester that did not win the previous tie goes first.
                grant_a         = (last_grant == GRANT_M);
                grant_m         = (last_grant == GRANT_A);
                last_grant_next = (last_grant == GRANT_M) ? GRANT_A : GRANT_M;
            end
        end else begin
            grant_a = a_full;
            grant_m = m_full;
        end
    end

    // A buffer draining this cycle can take a new request on the same edge.
    assign A_READY  = !RESET && (!a_full || grant_a);
    assign M_READY  = !RESET && (!m_full || grant_m);
    assign a_accept = A_VALID && A_READY;
    assign m_accept = M_VALID && M_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            a_full <= 1'b0;
            m_full <= 1'b0;
        end else begin
            if (a_accept)     a_full <= 1'b1;
            else if (grant_a) a_full <= 1'b0;
            if (m_accept)     m_full <= 1'b1;
            else if (grant_m) m_full <= 1'b0;
        end
    end

    // NOTE: payload registers are deliberately not reset; they are only read while the matching full flag is set.
    always_ff @(posedge CLK) begin
        if (a_accept) begin
            a_addr <= A_ADDR;
            a_data <= A_DATA;
        end
        if (m_accept) begin
            m_addr <= M_ADDR;
            m_data <= M_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else begin
            WRITE <= grant_a || grant_m;
            if (grant_a) begin
                INADDRESS <= a_addr;
                IN        <= a_data;
            end else if (grant_m) begin
                INADDRESS <= m_addr;
                IN        <= m_data;
            end
        end
    end

`ifdef REGWR_HAZARD_EN
    // Any write not yet visible in the register file that targets a register being read.
    always_comb begin
        HAZARD = 1'b0;
        if (a_full && (a_addr == RD1_ADDR || a_addr == RD2_ADDR))       HAZARD = 1'b1;
        if (m_full && (m_addr == RD1_ADDR || m_addr == RD2_ADDR))       HAZARD = 1'b1;
        if (WRITE && (INADDRESS == RD1_ADDR || INADDRESS == RD2_ADDR)) HAZARD = 1'b1;
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a write scoreboard and a register-file model.
// Hazard steps are compiled in only when REGWR_HAZARD_EN is defined.
module tb_reg_write_arbiter;

    typedef struct packed {
        logic [2:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       CLK;
    logic       RESET;
    logic       A_VALID, A_READY, M_VALID, M_READY;
    logic [2:0] A_ADDR, M_ADDR, INADDRESS;
    logic [7:0] A_DATA, M_DATA, IN;
    logic       WRITE;
`ifdef REGWR_HAZARD_EN
    logic [2:0] RD1_ADDR, RD2_ADDR;
    logic       HAZARD;
`endif

    int   checks = 0;
    int   errors = 0;
    wr_t  sb[$];
    logic [7:0] rf [8];
    int   a_i, m_i;
    logic exp_ar, exp_mr;

    reg_write_arbiter #(.DATA_W(8), .ADDR_W(3), .PRIO_MODE(0)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_ADDR(A_ADDR), .A_DATA(A_DATA),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_ADDR(M_ADDR), .M_DATA(M_DATA),
`ifdef REGWR_HAZARD_EN
        .RD1_ADDR(RD1_ADDR), .RD2_ADDR(RD2_ADDR), .HAZARD(HAZARD),
`endif
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) if (WRITE === 1'b1) rf[INADDRESS] <= IN;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic wr_t mk(input logic [2:0] addr, input logic [7:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Every WRITE pulse must match the oldest outstanding expected write.
    always @(negedge CLK) begin
        if (WRITE === 1'b1) begin
            check("write_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("write_addr", 32'(INADDRESS), 32'(e.addr));
                check("write_data", 32'(IN), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; A_VALID = 1'b1; A_ADDR = 3'd5; A_DATA = 8'hFF;
        M_VALID = 1'b0; M_ADDR = 3'd0; M_DATA = 8'h00;
`ifdef REGWR_HAZARD_EN
        RD1_ADDR = 3'd0; RD2_ADDR = 3'd0;
`endif
        // Reset held two cycles with A requesting
        tick(); tick(); @(negedge CLK);
        check("rst_a_ready", 32'(A_READY), 32'd0);
        check("rst_m_ready", 32'(M_READY), 32'd0);
        check("rst_write", 32'(WRITE), 32'd0);
        check("rst_inaddress", 32'(INADDRESS), 32'd0);
        check("rst_in", 32'(IN), 32'd0);
        tick(); RESET = 1'b0; A_VALID = 1'b0; @(negedge CLK);
        check("post_rst_a_ready", 32'(A_READY), 32'd1);
        check("post_rst_m_ready", 32'(M_READY), 32'd1);

        // Single A write and its latency
        tick(); A_VALID = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h11; sb.push_back(mk(3'd2, 8'h11));
        @(negedge CLK); check("single_a_ready", 32'(A_READY), 32'd1);
        tick(); A_VALID = 1'b0; @(negedge CLK);
        check("single_latency_write", 32'(WRITE), 32'd0);
        tick(); @(negedge CLK);
        check("single_write", 32'(WRITE), 32'd1);
        check("single_inaddress", 32'(INADDRESS), 32'd2);
        check("single_in", 32'(IN), 32'h11);
        tick(); @(negedge CLK);
        check("single_write_drop", 32'(WRITE), 32'd0);
        check("single_in_hold", 32'(IN), 32'h11);

        // Tie on the same register: A first (reset last_grant=M), then M wins in the file
        tick(); A_VALID = 1'b1; A_ADDR = 3'd1; A_DATA = 8'hAA;
        M_VALID = 1'b1; M_ADDR = 3'd1; M_DATA = 8'h55;
        sb.push_back(mk(3'd1, 8'hAA)); sb.push_back(mk(3'd1, 8'h55));
        @(negedge CLK);
        check("tie_a_ready", 32'(A_READY), 32'd1);
        check("tie_m_ready", 32'(M_READY), 32'd1);
        tick(); A_VALID = 1'b0; M_VALID = 1'b0;
        tick(); @(negedge CLK); check("tie_first_in", 32'(IN), 32'hAA);
        tick(); @(negedge CLK); check("tie_second_in", 32'(IN), 32'h55);
        tick(); @(negedge CLK); check("tie_rf1", 32'(rf[1]), 32'h55);

        // Full contention: last tie went to A, so M leads and the two alternate
        a_i = 0; m_i = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            A_VALID = 1'b1; A_ADDR = 3'd3; A_DATA = 8'hA0 + 8'(a_i);
            M_VALID = 1'b1; M_ADDR = 3'd6; M_DATA = 8'hC0 + 8'(m_i);
            exp_ar = (i == 0) || (i % 2 == 0);
            exp_mr = (i == 0) || (i % 2 == 1);
            @(negedge CLK);
            check("contend_a_ready", 32'(A_READY), 32'(exp_ar));
            check("contend_m_ready", 32'(M_READY), 32'(exp_mr));
            if (i >= 2) check("contend_write", 32'(WRITE), 32'd1);
            if (exp_mr) begin sb.push_back(mk(3'd6, 8'hC0 + 8'(m_i))); m_i++; end
            if (exp_ar) begin sb.push_back(mk(3'd3, 8'hA0 + 8'(a_i))); a_i++; end
        end
        tick(); A_VALID = 1'b0; M_VALID = 1'b0;
        repeat (5) tick();
        @(negedge CLK); check("contend_drained", 32'(sb.size()), 32'd0);

        // Back-to-back A, M idle
        for (int i = 0; i < 6; i++) begin
            tick(); A_VALID = 1'b1; A_ADDR = 3'(i); A_DATA = 8'h30 + 8'(i);
            sb.push_back(mk(3'(i), 8'h30 + 8'(i)));
            @(negedge CLK);
            check("b2b_a_ready", 32'(A_READY), 32'd1);
            if (i >= 2) check("b2b_write", 32'(WRITE), 32'd1);
        end
        tick(); A_VALID = 1'b0;
        repeat (3) tick();
        @(negedge CLK); check("b2b_drained", 32'(sb.size()), 32'd0);

        // Reset with both buffers full discards them
        tick(); A_VALID = 1'b1; A_ADDR = 3'd7; A_DATA = 8'hEE;
        M_VALID = 1'b1; M_ADDR = 3'd6; M_DATA = 8'hDD;
        @(negedge CLK); check("mid_a_ready", 32'(A_READY), 32'd1);
        tick(); A_VALID = 1'b0; M_VALID = 1'b0; RESET = 1'b1;
        @(negedge CLK); check("mid_rst_a_ready", 32'(A_READY), 32'd0);
        tick(); RESET = 1'b0; @(negedge CLK);
        check("mid_write", 32'(WRITE), 32'd0);
        check("mid_inaddress", 32'(INADDRESS), 32'd0);
        check("mid_in", 32'(IN), 32'd0);
        check("mid_a_ready_after", 32'(A_READY), 32'd1);
        check("mid_m_ready_after", 32'(M_READY), 32'd1);
        tick(); @(negedge CLK); check("mid_no_write1", 32'(WRITE), 32'd0);
        tick(); @(negedge CLK); check("mid_no_write2", 32'(WRITE), 32'd0);

        // Reset restores last_grant=M, so A wins the next tie again
        tick(); A_VALID = 1'b1; A_ADDR = 3'd2; A_DATA = 8'h12;
        M_VALID = 1'b1; M_ADDR = 3'd2; M_DATA = 8'h34;
        sb.push_back(mk(3'd2, 8'h12)); sb.push_back(mk(3'd2, 8'h34));
        tick(); A_VALID = 1'b0; M_VALID = 1'b0;
        repeat (3) tick();
        @(negedge CLK); check("rst_tie_rf2", 32'(rf[2]), 32'h34);

`ifdef REGWR_HAZARD_EN
        tick(); M_VALID = 1'b1; M_ADDR = 3'd4; M_DATA = 8'h44; sb.push_back(mk(3'd4, 8'h44));
        tick(); M_VALID = 1'b0; RD1_ADDR = 3'd0; RD2_ADDR = 3'd4;
        @(negedge CLK); check("hazard_buffered", 32'(HAZARD), 32'd1);
        #1 RD2_ADDR = 3'd1;
        #1 check("hazard_clear", 32'(HAZARD), 32'd0);
        tick(); RD1_ADDR = 3'd4; RD2_ADDR = 3'd0;
        @(negedge CLK); check("hazard_write_port", 32'(HAZARD), 32'd1);
        RD1_ADDR = 3'd0; RD2_ADDR = 3'd1;
`endif

        repeat (4) tick();
        @(negedge CLK); check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
